// File: rtl/rs_key_equation_bm.sv
// Inversionless Berlekamp-Massey key-equation solver for RS(255,239) over GF(2^8), t = 8.
// Optional macro RS_BM_ZERO_BYPASS_EN: all-zero syndrome frames skip the iterations.
module rs_key_equation_bm (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       Scalc_done,
  input  logic [7:0] Syndrome_in,
  output logic [7:0] Lambda_out,
  output logic       Lambda_valid,
  output logic [3:0] deg_out,
  output logic       bm_fail,
  output logic       busy,
  output logic       frame_drop
);
  localparam int DATA_W = 8;
  localparam int T      = 8;
  localparam int NS     = 2 * T;
  localparam logic [4:0] LAST_S = 5'(NS - 1);
  localparam logic [4:0] LAST_O = 5'(T);

  typedef enum logic [2:0] {IDLE, LOAD, ITER_D, ITER_U, OUT} state_t;
  state_t r_state, w_next;

  logic [DATA_W-1:0] r_syn [NS];
  logic [DATA_W-1:0] r_lam [T+1];
  logic [DATA_W-1:0] r_b   [T+1];
  logic [DATA_W-1:0] w_lam_upd [T+1];
  logic [DATA_W-1:0] w_xb  [T+1];
  logic [DATA_W-1:0] r_delta, r_gam, w_delta;
  logic [4:0]        r_len, r_cnt, w_deg_lam;
  logic              w_swap, w_fail;
  logic [3:0]        r_deg;
  logic              r_fail;

  // Shift-and-add multiply, reducing by x^8+x^4+x^3+x^2+1 after every shift.
  function automatic logic [DATA_W-1:0] gf_mul(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < DATA_W; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[DATA_W-1] ? ({aa[DATA_W-2:0], 1'b0} ^ 8'h1D) : {aa[DATA_W-2:0], 1'b0};
    end
    return p;
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_next;
  end

`ifdef RS_BM_ZERO_BYPASS_EN
  logic w_all_zero;
  always_comb begin
    w_all_zero = (Syndrome_in == '0);
    for (int k = 0; k < NS - 1; k++)
      if (r_syn[k] != '0) w_all_zero = 1'b0;
  end
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (Scalc_done) w_next = LOAD;
      LOAD:   if (r_cnt == LAST_S) begin
`ifdef RS_BM_ZERO_BYPASS_EN
        w_next = w_all_zero ? OUT : ITER_D;
`else
        w_next = ITER_D;
`endif
      end
      ITER_D: w_next = ITER_U;
      ITER_U: w_next = (r_cnt == LAST_S) ? OUT : ITER_D;
      OUT:    if (r_cnt == LAST_O) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Discrepancy for iteration r = r_cnt; syndromes below S_1 contribute nothing.
  always_comb begin
    logic [3:0] idx;
    w_delta = '0;
    idx     = '0;
    for (int i = 0; i <= T; i++) begin
      if (i <= int'(r_cnt)) begin
        idx     = r_cnt[3:0] - 4'(i);
        w_delta = w_delta ^ gf_mul(r_lam[i], r_syn[idx]);
      end
    end
  end

  always_comb begin
    w_xb[0] = '0;
    for (int j = 1; j <= T; j++) w_xb[j] = r_b[j-1];
    for (int j = 0; j <= T; j++)
      w_lam_upd[j] = gf_mul(r_gam, r_lam[j]) ^ gf_mul(r_delta, w_xb[j]);
    w_swap = (r_delta != '0) && ({r_len, 1'b0} <= {1'b0, r_cnt});
  end

  always_comb begin
    w_deg_lam = '0;
    for (int j = 1; j <= T; j++)
      if (r_lam[j] != '0) w_deg_lam = 5'(j);
    w_fail = (r_len > LAST_O) || (w_deg_lam != r_len);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cnt   <= '0;
      r_delta <= '0;
      r_gam   <= '0;
      r_len   <= '0;
      r_deg   <= '0;
      r_fail  <= 1'b0;
      for (int k = 0; k < NS; k++) r_syn[k] <= '0;
      for (int j = 0; j <= T; j++) begin
        r_lam[j] <= '0;
        r_b[j]   <= '0;
      end
    end else begin
      case (r_state)
        IDLE: if (Scalc_done) begin
          r_syn[0] <= Syndrome_in;
          r_cnt    <= 5'd1;
          for (int j = 0; j <= T; j++) begin
            r_lam[j] <= (j == 0) ? DATA_W'(1) : '0;
            r_b[j]   <= (j == 0) ? DATA_W'(1) : '0;
          end
          r_len   <= '0;
          r_gam   <= DATA_W'(1);
          r_delta <= '0;
        end
        LOAD: begin
          r_syn[r_cnt[3:0]] <= Syndrome_in;
          r_cnt <= (r_cnt == LAST_S) ? '0 : r_cnt + 5'd1;
        end
        ITER_D: r_delta <= w_delta;
        ITER_U: begin
          for (int j = 0; j <= T; j++) begin
            r_lam[j] <= w_lam_upd[j];
            r_b[j]   <= w_swap ? r_lam[j] : w_xb[j];
          end
          if (w_swap) begin
            r_len <= r_cnt + 5'd1 - r_len;
            r_gam <= r_delta;
          end
          r_cnt <= (r_cnt == LAST_S) ? '0 : r_cnt + 5'd1;
        end
        OUT: begin
          if (r_cnt == '0) begin
            r_deg  <= r_len[3:0];
            r_fail <= w_fail;
          end
          r_cnt <= (r_cnt == LAST_O) ? '0 : r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Status is live during OUT so it is visible on the first coefficient cycle.
  assign Lambda_valid = (r_state == OUT);
  assign Lambda_out   = Lambda_valid ? r_lam[r_cnt[3:0]] : '0;
  assign deg_out      = Lambda_valid ? r_len[3:0] : r_deg;
  assign bm_fail      = Lambda_valid ? w_fail : r_fail;
  assign busy         = (r_state != IDLE) || Scalc_done;
  assign frame_drop   = (r_state != IDLE) && Scalc_done;
endmodule

// File: tb/tb_rs_key_equation_bm.sv
// Bench for rs_key_equation_bm: table vectors, random error patterns checked against a
// log-table Berlekamp-Massey model and a root check, plus drop/reset/back-to-back sequences.
module tb_rs_key_equation_bm;
  logic       clk_in = 1'b0;
  logic       rst_in, Scalc_done;
  logic [7:0] Syndrome_in, Lambda_out;
  logic       Lambda_valid, bm_fail, busy, frame_drop;
  logic [3:0] deg_out;

  always #5 clk_in = ~clk_in;

  rs_key_equation_bm dut (
    .clk_in(clk_in), .rst_in(rst_in), .Scalc_done(Scalc_done), .Syndrome_in(Syndrome_in),
    .Lambda_out(Lambda_out), .Lambda_valid(Lambda_valid), .deg_out(deg_out),
    .bm_fail(bm_fail), .busy(busy), .frame_drop(frame_drop));

  localparam int NC = 128;
  typedef logic [15:0][7:0] syn_t;
  typedef logic [8:0][7:0]  lam_t;
  typedef struct packed { syn_t syn; lam_t lam; logic [3:0] deg; logic fail; } vec_t;

  logic       sd_a [NC];
  logic [7:0] syn_a[NC];
  logic       rst_a[NC];
  logic [7:0] o_lam[NC];
  logic [3:0] o_deg[NC];
  logic       o_vld[NC], o_busy[NC], o_drop[NC], o_fail[NC];
  int n_tests = 0, n_fail = 0;
  int gexp[0:254];
  int glog[0:255];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  // Inversionless BM straight from the algorithm statement, using log/antilog arithmetic.
  function automatic void bm_model(input syn_t S, output lam_t lam, output int L, output bit fail);
    int lm[0:8];
    int bb[0:8];
    int nw[0:8];
    int gam, d, dg;
    for (int j = 0; j <= 8; j++) begin lm[j] = 0; bb[j] = 0; end
    lm[0] = 1; bb[0] = 1; L = 0; gam = 1;
    for (int r = 0; r < 16; r++) begin
      d = 0;
      for (int i = 0; i <= 8; i++)
        if (r + 1 - i >= 1) d = d ^ gmul(lm[i], int'(S[r-i]));
      for (int j = 0; j <= 8; j++)
        nw[j] = gmul(gam, lm[j]) ^ ((j > 0) ? gmul(d, bb[j-1]) : 0);
      if (d != 0 && 2 * L <= r) begin
        bb = lm; L = r + 1 - L; gam = d;
      end else begin
        for (int j = 8; j > 0; j--) bb[j] = bb[j-1];
        bb[0] = 0;
      end
      lm = nw;
    end
    dg = 0;
    for (int j = 0; j <= 8; j++) if (lm[j] != 0) dg = j;
    fail = (L > 8) || (dg != L);
    lam = '0;
    for (int j = 0; j <= 8; j++) lam[j] = 8'(lm[j]);
  endfunction

  function automatic int lat_of(input syn_t S);
`ifdef RS_BM_ZERO_BYPASS_EN
    if (S == '0) return 16;
`endif
    return 48;
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < NC; c++) begin
      sd_a[c] = 1'b0; rst_a[c] = 1'b0; syn_a[c] = 8'($urandom);
    end
  endtask

  task automatic place_frame(input int c0, input syn_t S);
    sd_a[c0] = 1'b1;
    for (int k = 0; k < 16; k++) syn_a[c0+k] = S[k];
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1;
    rst_in = 1'b1; Scalc_done = 1'b0; Syndrome_in = '0;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
  endtask

  task automatic run();
    for (int c = 0; c < NC; c++) begin
      @(posedge clk_in); #1;
      Scalc_done = sd_a[c]; Syndrome_in = syn_a[c]; rst_in = rst_a[c];
      @(negedge clk_in);
      o_lam[c] = Lambda_out; o_vld[c] = Lambda_valid; o_deg[c] = deg_out;
      o_fail[c] = bm_fail; o_busy[c] = busy; o_drop[c] = frame_drop;
    end
    Scalc_done = 1'b0; rst_in = 1'b0;
  endtask

  task automatic check_frame(input string nm, input int c0, input lam_t el, input int ed,
                             input bit ef, input int lat);
    int s, bad;
    s = c0 + lat;
    bad = 0;
    for (int c = c0; c <= s + 11 && c < NC; c++) begin
      if (o_vld[c] !== (c >= s && c <= s + 8)) bad++;
      if (!o_vld[c] && o_lam[c] !== 8'd0) bad++;
    end
    chk({nm, "_valid_window"}, bad, 0);
    for (int k = 0; k <= 8; k++) chk($sformatf("%s_lam%0d", nm, k), int'(o_lam[s+k]), int'(el[k]));
    chk({nm, "_deg"}, int'(o_deg[s]), ed & 15);
    chk({nm, "_deg_held"}, int'(o_deg[s+9]), ed & 15);
    chk({nm, "_fail"}, int'(o_fail[s]), int'(ef));
    chk({nm, "_fail_held"}, int'(o_fail[s+9]), int'(ef));
    bad = 0;
    for (int c = c0; c <= s + 9; c++)
      if (o_busy[c] !== ((c <= s + 8) || sd_a[c])) bad++;
    chk({nm, "_busy_window"}, bad, 0);
  endtask

  task automatic check_drop(input string nm, input int dc);
    int bad;
    bad = 0;
    for (int c = 0; c < NC; c++) if (o_drop[c] !== (c == dc)) bad++;
    chk({nm, "_drop"}, bad, 0);
  endtask

  // Random correctable frame: returns syndromes of ne distinct errors plus their positions.
  task automatic make_err(input int ne, output syn_t S, output int p0, output int p1, output int p2,
                          output int p3, output int p4, output int p5, output int p6, output int p7);
    int pos[8];
    int yv[8];
    int p, acc;
    bit dup;
    for (int e = 0; e < 8; e++) begin pos[e] = 0; yv[e] = 0; end
    for (int e = 0; e < ne; e++) begin
      do begin
        p = $urandom_range(0, 254);
        dup = 1'b0;
        for (int q = 0; q < e; q++) if (pos[q] == p) dup = 1'b1;
      end while (dup);
      pos[e] = p;
      yv[e] = $urandom_range(1, 255);
    end
    for (int j = 1; j <= 16; j++) begin
      acc = 0;
      for (int e = 0; e < ne; e++) acc = acc ^ gmul(yv[e], gexp[(pos[e] * j) % 255]);
      S[j-1] = 8'(acc);
    end
    p0 = pos[0]; p1 = pos[1]; p2 = pos[2]; p3 = pos[3];
    p4 = pos[4]; p5 = pos[5]; p6 = pos[6]; p7 = pos[7];
  endtask

  initial begin
    vec_t vt[3];
    byte unsigned se[16];
    syn_t S, S2;
    lam_t el, el2;
    int eL, eL2, ne, v, bad, s;
    bit ef, ef2;
    int pp[8];

    rst_in = 1'b0; Scalc_done = 1'b0; Syndrome_in = '0;
    gexp[0] = 1;
    for (int i = 1; i < 255; i++) begin
      v = gexp[i-1] << 1;
      if ((v & 256) != 0) v = v ^ 285;
      gexp[i] = v;
    end
    glog[0] = 0;
    for (int i = 0; i < 255; i++) glog[gexp[i]] = i;

    se = '{1, 2, 4, 8, 16, 32, 64, 128, 29, 58, 116, 232, 205, 135, 19, 38};
    for (int i = 0; i < 3; i++) vt[i] = '0;
    vt[0].lam[0] = 8'd1;
    for (int k = 0; k < 16; k++) vt[1].syn[k] = se[k];
    vt[1].lam[0] = 8'd1; vt[1].lam[1] = 8'd2; vt[1].deg = 4'd1;
    vt[2].syn[0] = 8'd1; vt[2].lam[0] = 8'd1; vt[2].deg = 4'd1; vt[2].fail = 1'b1;

    for (int i = 0; i < 3; i++) begin
      clear_stim();
      place_frame(0, vt[i].syn);
      do_reset();
      run();
      check_frame($sformatf("vec%0d", i), 0, vt[i].lam, int'(vt[i].deg), vt[i].fail, lat_of(vt[i].syn));
      check_drop($sformatf("vec%0d", i), -1);
    end

    do_reset();
    @(negedge clk_in);
    chk("reset_lambda_out", int'(Lambda_out), 0);
    chk("reset_lambda_valid", int'(Lambda_valid), 0);
    chk("reset_deg_out", int'(deg_out), 0);
    chk("reset_bm_fail", int'(bm_fail), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_drop", int'(frame_drop), 0);

    for (int n = 0; n < 7; n++) begin
      ne = 0;
      if (n < 4) begin
        ne = (n == 0) ? 8 : $urandom_range(1, 8);
        make_err(ne, S, pp[0], pp[1], pp[2], pp[3], pp[4], pp[5], pp[6], pp[7]);
      end else begin
        for (int k = 0; k < 16; k++) S[k] = 8'($urandom);
      end
      bm_model(S, el, eL, ef);
      clear_stim();
      place_frame(0, S);
      do_reset();
      run();
      check_frame($sformatf("rnd%0d", n), 0, el, eL, ef, lat_of(S));
      if (n < 4) begin
        s = lat_of(S);
        chk($sformatf("rnd%0d_deg_vs_errors", n), int'(o_deg[s]), ne);
        bad = 0;
        for (int e = 0; e < ne; e++) begin
          v = 0;
          for (int k = 0; k <= 8; k++)
            v = v ^ gmul(int'(o_lam[s+k]), gexp[((255 - pp[e]) * k) % 255]);
          if (v != 0) bad++;
        end
        chk($sformatf("rnd%0d_roots", n), bad, 0);
      end
    end

    make_err(3, S, pp[0], pp[1], pp[2], pp[3], pp[4], pp[5], pp[6], pp[7]);
    bm_model(S, el, eL, ef);
    clear_stim();
    place_frame(0, S);
    sd_a[20] = 1'b1;
    do_reset();
    run();
    check_frame("drop", 0, el, eL, ef, 48);
    check_drop("drop", 20);

    make_err(2, S, pp[0], pp[1], pp[2], pp[3], pp[4], pp[5], pp[6], pp[7]);
    make_err(5, S2, pp[0], pp[1], pp[2], pp[3], pp[4], pp[5], pp[6], pp[7]);
    bm_model(S2, el2, eL2, ef2);
    clear_stim();
    place_frame(0, S);
    rst_a[30] = 1'b1;
    place_frame(40, S2);
    run();
    bad = 0;
    for (int c = 0; c < 88; c++) if (o_vld[c]) bad++;
    chk("rst_no_valid_before_88", bad, 0);
    chk("rst_busy_after", int'(o_busy[31]), 0);
    chk("rst_deg_after", int'(o_deg[31]), 0);
    check_frame("rst_b", 40, el2, eL2, ef2, 48);
    check_drop("rst", -1);

    make_err(4, S, pp[0], pp[1], pp[2], pp[3], pp[4], pp[5], pp[6], pp[7]);
    for (int k = 0; k < 16; k++) S2[k] = 8'($urandom);
    bm_model(S, el, eL, ef);
    bm_model(S2, el2, eL2, ef2);
    clear_stim();
    place_frame(0, S);
    place_frame(57, S2);
    do_reset();
    run();
    check_frame("b2b_a", 0, el, eL, ef, 48);
    check_frame("b2b_b", 57, el2, eL2, ef2, 48);
    check_drop("b2b", -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
